audio_frame_scheduler: RTL
==========================

# audio_frame_scheduler

Sequences the audio datapath into the FFT. Accepts codec samples on each `advance` strobe and decimates them. Writes them into a two-bank (ping-pong) frame buffer, then hands each full bank to the FFT core with a start/done handshake. Sits between the audio driver's ADC outputs and the FFT accelerator; it owns bank assignment, overrun detection and frame counting.

## Interface
- `SAMPLE_W`, 24: codec sample width.
- `FRAME_LEN`, 256: samples per frame; power of two, at least 4.
- `DECIM`, 1: keep one sample of every DECIM advance strobes; DECIM ≥ 1.
- `ADDR_W`, $clog2(FRAME_LEN): buffer address width (derived).

Ports:
- `clk`  in  1  system clock (50 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  level; capture runs while high.
- `advance`  in  1  single-cycle strobe, `clk`-synchronous, one per codec sample.
- `sample_in`  in  SAMPLE_W  ADC left sample; valid when `advance`=1.
- `clear_ovf`  in  1  pulse; clears `overrun`.
- `wr_en`  out  1  buffer write strobe.
- `wr_bank`  out  1  bank being written.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  SAMPLE_W  write data.
- `fft_start`  out  1  single-cycle pulse; FFT may process `fft_bank`.
- `fft_bank`  out  1  bank handed to FFT; held until next start.
- `fft_done`  in  1  single-cycle pulse; FFT has finished reading the bank.
- `overrun`  out  1  sticky; set when a sample was dropped.
- `drop_count`  out  16  dropped samples, saturating at 0xFFFF.
- `frame_count`  out  16  frames handed off, wraps.

## Operation
- States: IDLE, FILL, STALL.
- IDLE: no writes. When `enable`=1, go to FILL with addr=0. Fill bank = ~`fft_bank` if `fft_owned`, else 0.
- Decimator: a counter 0..DECIM-1 advances on each `advance`. A sample is *accepted* when `advance`=1 and the counter is 0. The counter resets in IDLE.
- FILL, accepted sample: write `sample_in` at (fill bank, addr), then addr++.
- FILL, write at addr=FRAME_LEN-1: the frame is full.
  - If `fft_owned`=0 (or `fft_done` arrives in the same cycle), schedule `fft_start` with `fft_bank`=fill bank. Then set `fft_owned`, toggle fill bank, set addr=0 and stay in FILL.
  - Otherwise go to STALL.
- STALL: accepted samples are dropped. `overrun` is set and `drop_count`++ (saturating). On `fft_done`, schedule the start for the full bank, toggle the bank, set addr=0 and go to FILL.
- `fft_owned` is set on `fft_start` and cleared on `fft_done`. Start and done in the same cycle leave it set.
- `enable` falling in FILL/STALL: go to IDLE next cycle. A partial frame is discarded. A full pending bank in STALL is discarded and no start is issued. An FFT already in progress keeps its bank, and `fft_done` is still tracked in IDLE.
- `clear_ovf` clears `overrun` only; `drop_count` is unchanged. If a drop occurs in the same cycle, set wins.
- `fft_done` while `fft_owned`=0 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, `fft_owned`=0, addr=0, decimator=0, fill bank 0.
- Write latency is 1: an accepted `advance` at cycle n gives `wr_en`/`wr_bank`/`wr_addr`/`wr_data` registered at n+1, each high for exactly 1 cycle.
- Handoff: last write at n+1, `fft_start` at n+2, with `fft_bank` and `frame_count`+1 valid the same cycle.
- From STALL: `fft_done` at cycle m gives `fft_start` at m+1. A sample accepted at m+1 or later goes to the new bank at addr 0.
- `advance` may arrive on consecutive cycles. The block sustains one write per cycle with no loss while a bank is free.
- Reset asserted mid-operation clears everything immediately. No `fft_start` follows.

## Structure
- Shared `audio_pkg` holds:
  - `sched_state_t` enum {IDLE, FILL, STALL};
  - `SAMPLE_W` default;
  - `frame_addr_t` typedef.
- The decimator (`sample_decimator`: strobe counter with an `accept` output) is one sub-module. Everything else lives in one FSM module.

## Test plan
- FRAME_LEN=4, DECIM=1, `fft_done` returned 10 cycles after each start: 8 strobes → writes bank0 addr0-3 then bank1 addr0-3. `fft_start` pulses with bank 0 then bank 1; `frame_count`=2; `overrun`=0.
- DECIM=3, 12 strobes, FRAME_LEN=4: exactly strobes 1,4,7,10 written to addr 0-3, then one `fft_start`.
- `fft_done` withheld, 12 strobes: banks 0 and 1 fill, state STALL, `overrun`=1, `drop_count`=4. Then `fft_done` → `fft_start` bank 1 next cycle, and the next sample goes to bank 0 addr 0.
- Last write of a frame in the same cycle as `fft_done`: no STALL, `fft_start` 1 cycle after the write, `drop_count`=0.
- `enable` dropped after 2 samples, then raised again: no start issued, and refill begins at addr 0 of the correct free bank.
- `reset_n` pulsed low mid-frame, asynchronous to `clk`: all outputs 0 immediately; after release, first accepted sample goes to bank 0 addr 0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio capture path.
package audio_pkg;

  // Default codec sample width.
  localparam int SAMPLE_W_DEFAULT = 24;

  // Default frame length and matching buffer address width.
  localparam int FRAME_LEN_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT    = $clog2(FRAME_LEN_DEFAULT);

  // Frame buffer address for the default frame length.
  typedef logic [ADDR_W_DEFAULT-1:0] frame_addr_t;

  // Capture scheduler states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    STALL = 2'd2
  } sched_state_t;

endpackage

// File: rtl/sample_decimator.sv
// Strobe counter that keeps one codec sample out of every DECIM strobes.
module sample_decimator #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_strobe,
  output logic o_accept
);

  localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

  logic [CNT_W-1:0] r_cnt;

  // Count strobes 0..DECIM-1, restarting at 0 while cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_strobe) begin
      r_cnt <= (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_accept = i_strobe && (r_cnt == '0);

endmodule

// File: rtl/audio_frame_scheduler.sv
// Ping-pong frame buffer scheduler: decimates codec samples, fills banks,
// hands full banks to the FFT and tracks overruns and frame counts.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int DECIM     = 1,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                advance,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                clear_ovf,
  output logic                wr_en,
  output logic                wr_bank,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                fft_start,
  output logic                fft_bank,
  input  logic                fft_done,
  output logic                overrun,
  output logic [15:0]         drop_count,
  output logic [15:0]         frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  // Registered state
  sched_state_t        r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_fill_bank;
  logic                r_fft_owned;
  logic                r_start_pend;
  logic                r_pend_bank;
  logic                r_wr_en;
  logic                r_wr_bank;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [SAMPLE_W-1:0] r_wr_data;
  logic                r_fft_start;
  logic                r_fft_bank;
  logic                r_overrun;
  logic [15:0]         r_drop_count;
  logic [15:0]         r_frame_count;

  // Next-state values and internal strobes
  sched_state_t        w_state_nx;
  logic [ADDR_W-1:0]   w_addr_nx;
  logic                w_fill_bank_nx;
  logic                w_fft_owned_nx;
  logic                w_start_pend_nx;
  logic                w_pend_bank_nx;
  logic                w_wr_en_nx;
  logic                w_wr_bank_nx;
  logic [ADDR_W-1:0]   w_wr_addr_nx;
  logic [SAMPLE_W-1:0] w_wr_data_nx;
  logic                w_fft_start_nx;
  logic                w_fft_bank_nx;
  logic                w_overrun_nx;
  logic [15:0]         w_drop_count_nx;
  logic [15:0]         w_frame_count_nx;
  logic                w_accept;
  logic                w_done_ok;
  logic                w_stall_start;
  logic                w_drop;
  logic                w_start_req;
  logic                w_start_bank;

  sample_decimator #(
    .DECIM (DECIM)
  ) u_decim (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (r_state == IDLE),
    .i_strobe (advance),
    .o_accept (w_accept)
  );

  // A done pulse only counts while the FFT actually holds a bank.
  assign w_done_ok = fft_done && r_fft_owned;

  // Capture FSM: bank/address sequencing and the buffer write port.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    w_state_nx      = r_state;
    w_addr_nx       = r_addr;
    w_fill_bank_nx  = r_fill_bank;
    w_start_pend_nx = 1'b0;
    w_pend_bank_nx  = r_pend_bank;
    w_wr_en_nx      = 1'b0;
    w_wr_bank_nx    = 1'b0;
    w_wr_addr_nx    = '0;
    w_wr_data_nx    = '0;
    w_stall_start   = 1'b0;
    w_drop          = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nx     = FILL;
          w_addr_nx      = '0;
          w_fill_bank_nx = r_fft_owned ? ~r_fft_bank : 1'b0;
        end
      end
      FILL: begin
        if (!enable) begin
          w_state_nx = IDLE;
        end else if (w_accept) begin
          w_wr_en_nx   = 1'b1;
          w_wr_bank_nx = r_fill_bank;
          w_wr_addr_nx = r_addr;
          w_wr_data_nx = sample_in;
          if (r_addr == LAST_ADDR) begin
            if (!r_fft_owned || w_done_ok) begin
              // Start goes out one cycle after the final write appears.
              w_start_pend_nx = 1'b1;
              w_pend_bank_nx  = r_fill_bank;
              w_fill_bank_nx  = ~r_fill_bank;
              w_addr_nx       = '0;
            end else begin
              w_state_nx = STALL;
            end
          end else begin
            w_addr_nx = r_addr + 1'b1;
          end
        end
      end
      STALL: begin
        if (!enable) begin
          w_state_nx = IDLE;
        end else begin
          w_drop = w_accept;
          if (w_done_ok) begin
            w_stall_start  = 1'b1;
            w_fill_bank_nx = ~r_fill_bank;
            w_addr_nx      = '0;
            w_state_nx     = FILL;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // FFT handoff, bank ownership, overrun and frame/drop counters.
  always_comb begin
    w_start_req      = r_start_pend || w_stall_start;
    // In STALL the fill bank still names the full bank awaiting handoff.
    w_start_bank     = r_start_pend ? r_pend_bank : r_fill_bank;
    w_fft_start_nx   = w_start_req;
    w_fft_bank_nx    = w_start_req ? w_start_bank : r_fft_bank;
    w_frame_count_nx = w_start_req ? r_frame_count + 16'd1 : r_frame_count;
    // A new start outranks a done in the same cycle.
    w_fft_owned_nx   = w_start_req ? 1'b1 : (w_done_ok ? 1'b0 : r_fft_owned);
    w_overrun_nx     = w_drop ? 1'b1 : (clear_ovf ? 1'b0 : r_overrun);
    w_drop_count_nx  = (w_drop && (r_drop_count != 16'hFFFF)) ? r_drop_count + 16'd1
                                                              : r_drop_count;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_fill_bank   <= 1'b0;
      r_fft_owned   <= 1'b0;
      r_start_pend  <= 1'b0;
      r_pend_bank   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_bank     <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_fft_start   <= 1'b0;
      r_fft_bank    <= 1'b0;
      r_overrun     <= 1'b0;
      r_drop_count  <= '0;
      r_frame_count <= '0;
    end else begin
      // NOTE: non-blocking so every register updates from the same pre-edge values.
      r_state       <= w_state_nx;
      r_addr        <= w_addr_nx;
      r_fill_bank   <= w_fill_bank_nx;
      r_fft_owned   <= w_fft_owned_nx;
      r_start_pend  <= w_start_pend_nx;
      r_pend_bank   <= w_pend_bank_nx;
      r_wr_en       <= w_wr_en_nx;
      r_wr_bank     <= w_wr_bank_nx;
      r_wr_addr     <= w_wr_addr_nx;
      r_wr_data     <= w_wr_data_nx;
      r_fft_start   <= w_fft_start_nx;
      r_fft_bank    <= w_fft_bank_nx;
      r_overrun     <= w_overrun_nx;
      r_drop_count  <= w_drop_count_nx;
      r_frame_count <= w_frame_count_nx;
    end
  end

  assign wr_en       = r_wr_en;
  assign wr_bank     = r_wr_bank;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign fft_start   = r_fft_start;
  assign fft_bank    = r_fft_bank;
  assign overrun     = r_overrun;
  assign drop_count  = r_drop_count;
  assign frame_count = r_frame_count;

endmodule
